// File: rtl/vend_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vend_pkg
// Description : Shared coin codes and coin-acceptor state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCK    = 2'd2,
        JAM     = 2'd3
    } acc_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Generic 1-bit two-flop synchronizer, async active-low reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : coin_acceptor
// Description : Measures coin-sensor pulse width and classifies it into a coin
//               code, reject pulse or jam flag, with a post-coin lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_acceptor
    import vend_pkg::*;
#(
    parameter int MIN1    = 4,
    parameter int MAX1    = 8,
    parameter int MIN2    = 12,
    parameter int MAX2    = 20,
    parameter int LOCKOUT = 16,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor,
    input  logic       en,
    output logic [1:0] coin,
    output logic       reject,
    output logic       jam,
    output logic       busy
);

    localparam int LCNT_W = $clog2(LOCKOUT + 1);

    localparam logic [CNT_W-1:0]  c_JAM_T     = '1;
    localparam logic [CNT_W-1:0]  c_JAM_PRE   = c_JAM_T - CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_MIN1      = CNT_W'(MIN1);
    localparam logic [CNT_W-1:0]  c_MAX1      = CNT_W'(MAX1);
    localparam logic [CNT_W-1:0]  c_MIN2      = CNT_W'(MIN2);
    localparam logic [CNT_W-1:0]  c_MAX2      = CNT_W'(MAX2);
    localparam logic [LCNT_W-1:0] c_LOCK_LAST = LCNT_W'(LOCKOUT - 1);

    if (!(MIN1 >= 1 && MIN1 <= MAX1 && MAX1 < MIN2 && MIN2 <= MAX2 &&
          MAX2 < (1 << CNT_W) - 1 && LOCKOUT >= 1)) begin : g_param_check
        $error("coin_acceptor: illegal width-window or lockout parameters");
    end

    logic              w_sensor_s;
    acc_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [LCNT_W-1:0] r_lcnt, w_lcnt_nxt;
    logic [1:0]        r_coin, w_coin_nxt;
    logic              r_reject, w_reject_nxt;
    logic              r_jam, w_jam_nxt;
    logic              r_busy, w_busy_nxt;

    sync_2ff u_sensor_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sensor),
        .q     (w_sensor_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_lcnt   <= '0;
            r_coin   <= COIN_NONE;
            r_reject <= 1'b0;
            r_jam    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_lcnt   <= w_lcnt_nxt;
            r_coin   <= w_coin_nxt;
            r_reject <= w_reject_nxt;
            r_jam    <= w_jam_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_lcnt_nxt   = r_lcnt;
        w_coin_nxt   = COIN_NONE;
        w_reject_nxt = 1'b0;
        w_jam_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && w_sensor_s) begin
                    w_state_nxt = MEASURE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            MEASURE: begin
                if (w_sensor_s) begin
                    // Reaching the all-ones count while still blocked is a jam.
                    if (r_cnt == c_JAM_PRE) begin
                        w_state_nxt = JAM;
                        w_cnt_nxt   = c_JAM_T;
                        w_jam_nxt   = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end else begin
                    if (r_cnt >= c_MIN1 && r_cnt <= c_MAX1) begin
                        w_coin_nxt = COIN_1;
                    end else if (r_cnt >= c_MIN2 && r_cnt <= c_MAX2) begin
                        w_coin_nxt = COIN_2;
                    end else begin
                        w_reject_nxt = 1'b1;
                    end
                    w_state_nxt = LOCK;
                    w_lcnt_nxt  = '0;
                end
            end
            LOCK: begin
                if (r_lcnt == c_LOCK_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_lcnt_nxt = r_lcnt + LCNT_W'(1);
                end
            end
            JAM: begin
                if (w_sensor_s) begin
                    w_jam_nxt = 1'b1;
                end else begin
                    w_state_nxt = LOCK;
                    w_lcnt_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    assign coin   = r_coin;
    assign reject = r_reject;
    assign jam    = r_jam;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_coin_acceptor.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_acceptor
// Description : Directed self-checking bench for coin_acceptor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_acceptor;

    logic       clk;
    logic       rst_n;
    logic       sensor;
    logic       en;
    logic [1:0] coin;
    logic       reject;
    logic       jam;
    logic       busy;

    int         n_checks;
    int         n_fail;
    int         cyc;
    int         fall_cyc;
    int         ev_coin;
    int         ev_rej;
    int         first_lat;
    logic [1:0] last_code;

    coin_acceptor dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sensor (sensor),
        .en     (en),
        .coin   (coin),
        .reject (reject),
        .jam    (jam),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (coin != 2'b00) begin
            ev_coin++;
            last_code = coin;
            if (first_lat < 0) first_lat = cyc - fall_cyc;
        end
        if (reject) begin
            ev_rej++;
            if (first_lat < 0) first_lat = cyc - fall_cyc;
        end
    endtask

    task automatic clear_ev();
        ev_coin   = 0;
        ev_rej    = 0;
        first_lat = -1;
        last_code = 2'b00;
    endtask

    task automatic pulse(input int w, input int drop_at);
        sensor = 1'b1;
        for (int i = 0; i < w; i++) begin
            if (i == drop_at) en = 1'b0;
            tick();
        end
        sensor   = 1'b0;
        fall_cyc = cyc;
        repeat (4) tick();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic coin_case(input string tag, input int w, input logic [1:0] code, input int drop_at);
        clear_ev();
        pulse(w, drop_at);
        en = 1'b1;
        wait_idle({tag, "_idle"});
        check({tag, "_code"}, {30'd0, last_code}, {30'd0, code});
        check({tag, "_ncoin"}, ev_coin, 1);
        check({tag, "_nrej"}, ev_rej, 0);
        check({tag, "_lat"}, first_lat, 3);
    endtask

    task automatic reject_case(input string tag, input int w);
        clear_ev();
        pulse(w, -1);
        wait_idle({tag, "_idle"});
        check({tag, "_nrej"}, ev_rej, 1);
        check({tag, "_ncoin"}, ev_coin, 0);
        check({tag, "_lat"}, first_lat, 3);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        fall_cyc = 0;
        clear_ev();
        rst_n  = 1'b0;
        sensor = 1'b0;
        en     = 1'b1;

        // Reset held with a toggling sensor
        for (int i = 0; i < 8; i++) begin
            sensor = ~sensor;
            tick();
        end
        check("rst_coin", {30'd0, coin}, 32'd0);
        check("rst_reject", {31'd0, reject}, 32'd0);
        check("rst_jam", {31'd0, jam}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        sensor = 1'b0;
        rst_n  = 1'b1;
        clear_ev();
        repeat (5) tick();
        check("post_rst_busy", {31'd0, busy}, 32'd0);
        check("post_rst_events", ev_coin + ev_rej, 0);

        // Small coin with exact latency and lockout length
        clear_ev();
        pulse(6, -1);
        check("w6_code", {30'd0, last_code}, 32'd1);
        check("w6_ncoin", ev_coin, 1);
        check("w6_lat", first_lat, 3);
        repeat (14) tick();
        check("w6_busy_lock_end", {31'd0, busy}, 32'd1);
        tick();
        check("w6_busy_idle", {31'd0, busy}, 32'd0);
        check("w6_nrej", ev_rej, 0);

        // Window boundaries
        coin_case("w12", 12, 2'b10, -1);
        coin_case("w20", 20, 2'b10, -1);
        coin_case("w8", 8, 2'b01, -1);
        coin_case("w4", 4, 2'b01, -1);

        // Out-of-window widths
        reject_case("w3", 3);
        reject_case("w10", 10);
        reject_case("w21", 21);

        // Second pulse inside lockout is ignored
        clear_ev();
        pulse(6, -1);
        check("lk_first_ncoin", ev_coin, 1);
        clear_ev();
        pulse(6, -1);
        wait_idle("lk_idle");
        check("lk_second_ncoin", ev_coin, 0);
        check("lk_second_nrej", ev_rej, 0);

        // Disabled acceptor ignores sensor
        en = 1'b0;
        clear_ev();
        pulse(6, -1);
        repeat (4) tick();
        check("en0_busy", {31'd0, busy}, 32'd0);
        check("en0_events", ev_coin + ev_rej, 0);
        en = 1'b1;
        tick();

        // Enable dropped mid-measurement
        coin_case("endrop_w15", 15, 2'b10, 5);

        // Jam: flag rises on the 63rd synchronized high sample
        clear_ev();
        sensor = 1'b1;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 64) check("jam_before", {31'd0, jam}, 32'd0);
            if (i == 65) check("jam_set", {31'd0, jam}, 32'd1);
        end
        check("jam_held", {31'd0, jam}, 32'd1);
        sensor   = 1'b0;
        fall_cyc = cyc;
        tick();
        tick();
        check("jam_still", {31'd0, jam}, 32'd1);
        tick();
        check("jam_clear", {31'd0, jam}, 32'd0);
        check("jam_lock_busy", {31'd0, busy}, 32'd1);
        wait_idle("jam_idle");
        check("jam_events", ev_coin + ev_rej, 0);

        // Asynchronous reset in the middle of a measurement
        clear_ev();
        sensor = 1'b1;
        repeat (6) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        sensor = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (10) tick();
        check("mid_rst_events", ev_coin + ev_rej, 0);
        check("mid_rst_idle", {31'd0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
